hmmm_loader: RTL and testbench

Serial program loader that sits directly upstream of the hmmm CPU core. It receives a framed, MSB-first serial stream containing a word count followed by program words. Each word is written into CPU RAM through the core's pgrm_addr/pgrm_data/in path, at addresses 0..N-1 in order. After a successful load it pulses the CPU reset so execution starts from a clean state.

---
 rtl/hmmm_loader_if.sv | 28 ++
 rtl/hmmm_loader.sv | 203 ++++++++++++++++++++
 tb/tb_hmmm_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/hmmm_loader_if.sv
// Bundles the loader's serial input pins and its program-load/status outputs.
// master drives the serial frame (host side); slave is the loader itself.
interface hmmm_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              ser_cs_n;
    logic              ser_clk;
    logic              ser_data;
    logic              pgrm_addr;
    logic              pgrm_data;
    logic [DATA_W-1:0] pgrm_bus;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    modport master (
        output ser_cs_n, ser_clk, ser_data,
        input  pgrm_addr, pgrm_data, pgrm_bus, cpu_rst, busy, done, error, word_count
    );

    modport slave (
        input  ser_cs_n, ser_clk, ser_data,
        output pgrm_addr, pgrm_data, pgrm_bus, cpu_rst, busy, done, error, word_count
    );
endinterface

// File: rtl/hmmm_loader.sv
// Serial program loader for the hmmm core: receives {count, words...} MSB-first,
// writes each word to RAM via address/data strobes, then pulses the CPU reset.
module hmmm_loader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RST_CYCLES  = 4
) (
    input  logic         clk,
    input  logic         rst,
    hmmm_loader_if.slave bus
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [ADDR_W:0]   N_MAX    = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, W_ADDR, W_DATA, RST_CPU, DONE, ERR
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_p0;
    logic [SYNC_STAGES-1:0] sclk_sync_p0;
    logic [SYNC_STAGES-1:0] sd_sync_p0;
    logic                   cs_last_p1;
    logic                   sclk_last_p1;

    logic                   cs_s;
    logic                   sclk_s;
    logic                   sd_s;
    logic                   bit_event;
    logic                   cs_fall;

    logic [BIT_W-1:0]       bitcnt_p1;
    logic [DATA_W-1:0]      shreg_p1;
    logic                   word_rdy_p1;

    logic [ADDR_W:0]        hdr_n;
    logic                   hdr_ok;
    logic [ADDR_W:0]        n_q;
    logic [DATA_W-1:0]      word_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [ADDR_W:0]        wcnt_q;
    logic [RC_W-1:0]        rcnt_q;
    logic                   frame_start;

    logic                   pgrm_addr_q;
    logic                   pgrm_data_q;
    logic [DATA_W-1:0]      pgrm_bus_q;
    logic                   cpu_rst_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;

    // ---- stage 0: input synchronizers and edge history ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync_p0   <= '1;
            sclk_sync_p0 <= '0;
            sd_sync_p0   <= '0;
            cs_last_p1   <= 1'b1;
            sclk_last_p1 <= 1'b0;
        end else begin
            cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], bus.ser_cs_n};
            sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], bus.ser_clk};
            sd_sync_p0   <= {sd_sync_p0[SYNC_STAGES-2:0], bus.ser_data};
            cs_last_p1   <= cs_s;
            sclk_last_p1 <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_p0[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
    assign sd_s      = sd_sync_p0[SYNC_STAGES-1];
    assign bit_event = sclk_s & ~sclk_last_p1 & ~cs_s;
    assign cs_fall   = cs_last_p1 & ~cs_s;

    // ---- stage 1: bit shifter and word boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt_p1   <= '0;
            shreg_p1    <= '0;
            word_rdy_p1 <= 1'b0;
        end else begin
            word_rdy_p1 <= 1'b0;
            if (cs_s) begin
                bitcnt_p1 <= '0;
            end else if (bit_event) begin
                shreg_p1 <= {shreg_p1[DATA_W-2:0], sd_s};
                if (bitcnt_p1 == BIT_LAST) begin
                    bitcnt_p1   <= '0;
                    word_rdy_p1 <= 1'b1;
                end else begin
                    bitcnt_p1 <= bitcnt_p1 + 1'b1;
                end
            end
        end
    end

    // Only the low ADDR_W+1 header bits form the count; anything above is ignored.
    assign hdr_n  = shreg_p1[ADDR_W:0];
    assign hdr_ok = (hdr_n != '0) && (hdr_n <= N_MAX);

    assign frame_start = cs_fall &&
                         ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

    // ---- stage 2: load sequencer ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (cs_fall) state_d = HDR;
            end
            HDR: begin
                if (word_rdy_p1) state_d = hdr_ok ? DATA : ERR;
                else if (cs_s)   state_d = ERR;
            end
            // A completed word is still written even if cs_n rises in the same cycle;
            // the abort is then taken on the return to DATA.
            DATA: begin
                if (word_rdy_p1) state_d = W_ADDR;
                else if (cs_s)   state_d = ERR;
            end
            W_ADDR: state_d = W_DATA;
            W_DATA: begin
                if ((wcnt_q + 1'b1) == n_q) state_d = RST_CPU;
                else                        state_d = DATA;
            end
            RST_CPU: begin
                if (rcnt_q == RC_LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q    <= '0;
            word_q <= '0;
            addr_q <= '0;
            wcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            if (frame_start) begin
                wcnt_q <= '0;
                addr_q <= '0;
            end
            if ((state_q == HDR) && word_rdy_p1) n_q <= hdr_n;
            if ((state_q == DATA) && word_rdy_p1) word_q <= shreg_p1;
            if (state_q == W_DATA) begin
                wcnt_q <= wcnt_q + 1'b1;
                if (state_d == DATA) addr_q <= addr_q + 1'b1;
            end
            rcnt_q <= (state_q == RST_CPU) ? rcnt_q + 1'b1 : '0;
        end
    end

    // ---- stage 3: registered outputs decoded from the next state ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pgrm_addr_q <= 1'b0;
            pgrm_data_q <= 1'b0;
            pgrm_bus_q  <= '0;
            cpu_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            pgrm_addr_q <= (state_d == W_ADDR);
            pgrm_data_q <= (state_d == W_DATA);
            if (state_d == W_ADDR)      pgrm_bus_q <= DATA_W'(addr_q);
            else if (state_d == W_DATA) pgrm_bus_q <= word_q;
            else                        pgrm_bus_q <= '0;
            cpu_rst_q   <= (state_d == RST_CPU);
            busy_q      <= (state_d == HDR) || (state_d == DATA) || (state_d == W_ADDR) ||
                           (state_d == W_DATA) || (state_d == RST_CPU);
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == ERR);
        end
    end

    assign bus.pgrm_addr  = pgrm_addr_q;
    assign bus.pgrm_data  = pgrm_data_q;
    assign bus.pgrm_bus   = pgrm_bus_q;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.word_count = wcnt_q;

endmodule

// File: tb/tb_hmmm_loader.sv
// Directed bench for hmmm_loader: table of frames plus hand sequences for
// mid-load reset, early header rejection and done clearing on a new frame.
module tb_hmmm_loader;

    localparam int HALF = 3;

    logic clk;
    logic rst_n;

    hmmm_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    hmmm_loader #(
        .ADDR_W(8), .DATA_W(16), .SYNC_STAGES(2), .RST_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Strobe / cpu_rst monitor, sampled on the falling edge.
    logic [15:0] aq[$];
    logic [15:0] dq[$];
    int  viol = 0;
    int  rst_cycles = 0;
    int  runs = 0;
    int  run = 0;
    logic prev_a = 1'b0;

    always @(negedge clk) begin
        if (bus.pgrm_addr && bus.pgrm_data) viol <= viol + 1;
        else if (!bus.pgrm_addr && !bus.pgrm_data && bus.pgrm_bus != 16'h0) viol <= viol + 1;
        else if (bus.pgrm_data && !prev_a) viol <= viol + 1;
        else if (prev_a && !bus.pgrm_data) viol <= viol + 1;
        if (bus.pgrm_addr) aq.push_back(bus.pgrm_bus);
        if (bus.pgrm_data) dq.push_back(bus.pgrm_bus);
        if (bus.cpu_rst) begin
            run <= run + 1;
            rst_cycles <= rst_cycles + 1;
        end else begin
            if (run != 0) runs <= runs + 1;
            run <= 0;
        end
        prev_a <= bus.pgrm_addr;
    end

    typedef struct {
        logic [15:0]      hdr;
        int               nw;
        logic [3:0][15:0] w;
        int               extra;
        bit               ramp;
        bit               exp_done;
        bit               exp_err;
        int               exp_wc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input vec_t v, input int i);
        if (v.ramp) return 16'(i);
        return v.w[2'(i)];
    endfunction

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int b = 0; b < n; b++) begin
            bus.ser_data = w[15-b];
            repeat (HALF) @(negedge clk);
            bus.ser_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.ser_clk = 1'b0;
        end
    endtask

    task automatic start_frame();
        bus.ser_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_frame();
        bus.ser_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int a0, d0, r0, ru0, v0, mism;
        a0 = aq.size(); d0 = dq.size(); r0 = rst_cycles; ru0 = runs; v0 = viol;
        start_frame();
        send_bits(v.hdr, 16);
        for (int i = 0; i < v.nw; i++) send_bits(word_of(v, i), 16);
        if (v.extra > 0) send_bits(16'hA5A5, v.extra);
        repeat (40) @(negedge clk);
        end_frame();
        chk({tag, " done"},  32'(bus.done),  32'(v.exp_done));
        chk({tag, " error"}, 32'(bus.error), 32'(v.exp_err));
        chk({tag, " busy"},  32'(bus.busy),  32'd0);
        chk({tag, " word_count"}, 32'(bus.word_count), 32'(v.exp_wc));
        chk({tag, " addr strobes"}, 32'(aq.size() - a0), 32'(v.exp_wc));
        chk({tag, " data strobes"}, 32'(dq.size() - d0), 32'(v.exp_wc));
        mism = 0;
        if ((aq.size() - a0 == v.exp_wc) && (dq.size() - d0 == v.exp_wc)) begin
            for (int i = 0; i < v.exp_wc; i++) begin
                if (aq[a0+i] !== 16'(i) || dq[d0+i] !== word_of(v, i)) mism++;
            end
            if (v.exp_wc > 0)
                chk({tag, " last addr"}, 32'(aq[a0+v.exp_wc-1]), 32'(v.exp_wc - 1));
        end
        chk({tag, " strobe contents"}, 32'(mism), 32'd0);
        chk({tag, " cpu_rst cycles"}, 32'(rst_cycles - r0), v.exp_done ? 32'd4 : 32'd0);
        chk({tag, " cpu_rst pulses"}, 32'(runs - ru0), v.exp_done ? 32'd1 : 32'd0);
        chk({tag, " strobe protocol"}, 32'(viol - v0), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pgrm_addr"},  32'(bus.pgrm_addr),  32'd0);
        chk({tag, " pgrm_data"},  32'(bus.pgrm_data),  32'd0);
        chk({tag, " pgrm_bus"},   32'(bus.pgrm_bus),   32'd0);
        chk({tag, " cpu_rst"},    32'(bus.cpu_rst),    32'd0);
        chk({tag, " busy"},       32'(bus.busy),       32'd0);
        chk({tag, " done"},       32'(bus.done),       32'd0);
        chk({tag, " error"},      32'(bus.error),      32'd0);
        chk({tag, " word_count"}, 32'(bus.word_count), 32'd0);
    endtask

    initial begin
        int a0, d0;
        bit hit;
        bus.ser_cs_n = 1'b1;
        bus.ser_clk  = 1'b0;
        bus.ser_data = 1'b0;
        rst_n = 1'b0;

        vecs[0] = '{16'h0003, 3, {16'h0000, 16'h0000, 16'hABCD, 16'h1234}, 0, 1'b0, 1'b1, 1'b0, 3};
        vecs[1] = '{16'h0000, 0, {16'h0, 16'h0, 16'h0, 16'h0},             0, 1'b0, 1'b0, 1'b1, 0};
        vecs[2] = '{16'h0201, 0, {16'h0, 16'h0, 16'h0, 16'h0},             0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{16'h0002, 0, {16'h0, 16'h0, 16'h0, 16'h0},             7, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{16'h0003, 2, {16'h0, 16'h0, 16'h2222, 16'h1111},       0, 1'b0, 1'b0, 1'b1, 2};
        vecs[5] = '{16'h0001, 1, {16'h0, 16'h0, 16'h0, 16'h00C3},          5, 1'b0, 1'b1, 1'b0, 1};
        vecs[6] = '{16'h0100, 256, {16'h0, 16'h0, 16'h0, 16'h0},           0, 1'b1, 1'b1, 1'b0, 256};
        vecs[7] = '{16'h0001, 1, {16'h0, 16'h0, 16'h0, 16'h00AA},          0, 1'b0, 1'b1, 1'b0, 1};

        repeat (4) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Out-of-range count is rejected as soon as the header completes.
        a0 = aq.size();
        start_frame();
        send_bits(16'h0101, 16);
        repeat (10) @(negedge clk);
        chk("hdr257 early error", 32'(bus.error), 32'd1);
        chk("hdr257 early busy",  32'(bus.busy),  32'd0);
        end_frame();
        chk("hdr257 strobes", 32'(aq.size() - a0), 32'd0);

        // Asynchronous reset during the W_DATA strobe of word 5 of 10.
        d0 = dq.size();
        start_frame();
        send_bits(16'h000A, 16);
        for (int i = 0; i < 5; i++) send_bits(16'h0100 + 16'(i), 16);
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(posedge clk); #1;
            if (bus.pgrm_data && (dq.size() - d0 == 4)) hit = 1'b1;
        end
        chk("rst mid-load reached W_DATA", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst mid-load");
        bus.ser_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_vec(vecs[7], "after rst");

        // New frame after DONE clears done at the cs_n fall, then reloads.
        a0 = aq.size(); d0 = dq.size();
        start_frame();
        chk("reload done cleared", 32'(bus.done), 32'd0);
        chk("reload busy set",     32'(bus.busy), 32'd1);
        send_bits(16'h0001, 16);
        send_bits(16'h5555, 16);
        repeat (40) @(negedge clk);
        chk("reload addr count", 32'(aq.size() - a0), 32'd1);
        chk("reload data count", 32'(dq.size() - d0), 32'd1);
        if (aq.size() - a0 == 1 && dq.size() - d0 == 1) begin
            chk("reload addr", 32'(aq[a0]), 32'h0);
            chk("reload data", 32'(dq[d0]), 32'h5555);
        end
        chk("reload done",       32'(bus.done),       32'd1);
        chk("reload word_count", 32'(bus.word_count), 32'd1);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
